// File: rtl/if_fetch.sv
// Instruction fetch: reads a 32-bit word little-endian over a byte-wide memory port, one byte per granted cycle.
// Word presented 6 cycles after capture with grant held high; grant low retries the slot, stall_i holds the output.
module if_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  ce_i,
  input  logic                  branch_flag_i,
  input  logic                  stall_i,
  input  logic                  mem_gnt_i,
  input  logic [7:0]            mem_din_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_valid_o,
  output logic                  stall_req_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [2:0]            issue_cnt;
  logic                  rx_valid;
  logic [1:0]            rx_idx;
  logic [7:0]            lane0;
  logic [7:0]            lane1;
  logic [7:0]            lane2;
  logic                  issue;
  logic                  rx_write;
  logic                  done;
  logic                  start;

  always_comb begin
    mem_rd_en_o = (state == FETCH) && !issue_cnt[2] && !branch_flag_i;
    mem_a_o     = fetch_pc + ADDR_WIDTH'(issue_cnt);
    issue       = mem_rd_en_o && mem_gnt_i;
    // A byte returning in the flush cycle belongs to the abandoned fetch.
    rx_write    = (state == FETCH) && rx_valid && !branch_flag_i;
    done        = rx_write && (rx_idx == 2'd3);
    start       = (state == IDLE) && ce_i && !branch_flag_i;
    stall_req_o = !((state == VALID) && !stall_i);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (branch_flag_i)  state_nxt = IDLE;
        else if (done)      state_nxt = VALID;
      end
      VALID: begin
        if (branch_flag_i || !stall_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= '0;
      issue_cnt <= '0;
      rx_valid  <= 1'b0;
      rx_idx    <= '0;
    end else begin
      if (start) begin
        fetch_pc  <= pc_i;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 3'd1;
      end
      rx_valid <= issue;
      if (issue) rx_idx <= issue_cnt[1:0];
    end
  end

  // Lane 3 is never stored: it completes the word straight into inst_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane0 <= '0;
      lane1 <= '0;
      lane2 <= '0;
    end else if (rx_write) begin
      case (rx_idx)
        2'd0:    lane0 <= mem_din_i;
        2'd1:    lane1 <= mem_din_i;
        2'd2:    lane2 <= mem_din_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_o       <= '0;
      pc_o         <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      if (done) begin
        inst_o <= {mem_din_i, lane2, lane1, lane0};
        pc_o   <= fetch_pc;
      end
      if (branch_flag_i)                     inst_valid_o <= 1'b0;
      else if (done)                         inst_valid_o <= 1'b1;
      else if ((state == VALID) && !stall_i) inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte memory model with one-cycle read latency.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        branch_flag_i;
  logic        stall_i;
  logic        mem_gnt_i;
  logic [7:0]  mem_din_i;
  logic        mem_rd_en_o;
  logic [31:0] mem_a_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        stall_req_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .branch_flag_i(branch_flag_i),
    .stall_i(stall_i), .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_a_o(mem_a_o), .inst_o(inst_o), .pc_o(pc_o),
    .inst_valid_o(inst_valid_o), .stall_req_o(stall_req_o)
  );

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h0000_0100: byte_at = 8'h13;
      32'h0000_0101: byte_at = 8'h05;
      32'h0000_0102: byte_at = 8'h10;
      32'h0000_0103: byte_at = 8'h00;
      32'h0000_0200: byte_at = 8'h93;
      32'h0000_0201: byte_at = 8'h02;
      32'h0000_0202: byte_at = 8'hA0;
      32'h0000_0203: byte_at = 8'h00;
      32'h0000_0300: byte_at = 8'h6F;
      32'h0000_0301: byte_at = 8'h00;
      32'h0000_0302: byte_at = 8'h00;
      32'h0000_0303: byte_at = 8'h00;
      32'hFFFF_FFFE: byte_at = 8'hB7;
      32'hFFFF_FFFF: byte_at = 8'h10;
      32'h0000_0000: byte_at = 8'h00;
      32'h0000_0001: byte_at = 8'h00;
      default:       byte_at = 8'hEE;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en_o && mem_gnt_i) mem_din_i <= byte_at(mem_a_o);
    else                          mem_din_i <= 8'h00;
  end

  // Leaves the bench at the sampling point of the first FETCH cycle.
  task automatic start_fetch(input logic [31:0] a);
    @(negedge clk); pc_i = a; ce_i = 1'b1;
    @(negedge clk); ce_i = 1'b0; #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (mem_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en_o); end
    checks++; if (mem_a_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_a_o); end
    checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %b expected 1", stall_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic;
    start_fetch(32'h100);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      checks++; if (mem_rd_en_o !== (c <= 4)) begin errors++; $display("FAIL basic_rd_en c%0d: got %b expected %b", c, mem_rd_en_o, (c <= 4)); end
      if (c <= 4) begin
        checks++; if (mem_a_o !== 32'h100 + c - 1) begin errors++; $display("FAIL basic_addr c%0d: got %h expected %h", c, mem_a_o, 32'h100 + c - 1); end
      end
      checks++; if (inst_valid_o !== (c == 6)) begin errors++; $display("FAIL basic_valid c%0d: got %b expected %b", c, inst_valid_o, (c == 6)); end
      checks++; if (stall_req_o !== (c != 6)) begin errors++; $display("FAIL basic_stall_req c%0d: got %b expected %b", c, stall_req_o, (c != 6)); end
      if (c == 6) begin
        checks++; if (inst_o !== 32'h0010_0513) begin errors++; $display("FAIL basic_inst: got %h expected 00100513", inst_o); end
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL basic_pc: got %h expected 00000100", pc_o); end
      end
    end
  endtask

  task automatic test_grant_gap;
    logic [31:0] exp_a;
    start_fetch(32'h100);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      mem_gnt_i = !(c >= 3 && c <= 5);
      exp_a = (c <= 2) ? 32'h100 + c - 1 : (c <= 6) ? 32'h102 : 32'h103;
      if (c <= 7) begin
        checks++; if (mem_a_o !== exp_a || mem_rd_en_o !== 1'b1) begin errors++; $display("FAIL gap_addr c%0d: got %h/%b expected %h/1", c, mem_a_o, mem_rd_en_o, exp_a); end
      end
      checks++; if (inst_valid_o !== (c == 9)) begin errors++; $display("FAIL gap_valid c%0d: got %b expected %b", c, inst_valid_o, (c == 9)); end
      if (c == 9) begin
        checks++; if (inst_o !== 32'h0010_0513) begin errors++; $display("FAIL gap_inst: got %h expected 00100513", inst_o); end
      end
    end
    mem_gnt_i = 1'b1;
  endtask

  task automatic test_flush;
    start_fetch(32'h100);
    @(negedge clk); #1;
    checks++; if (mem_a_o !== 32'h101) begin errors++; $display("FAIL flush_pre_addr: got %h expected 00000101", mem_a_o); end
    @(negedge clk);
    branch_flag_i = 1'b1; pc_i = 32'h200; ce_i = 1'b1; #1;
    checks++; if (mem_rd_en_o !== 1'b0) begin errors++; $display("FAIL flush_no_issue: got %b expected 0", mem_rd_en_o); end
    @(negedge clk); branch_flag_i = 1'b0; #1;
    checks++; if (mem_rd_en_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_idle: got rd_en=%b valid=%b expected 0/0", mem_rd_en_o, inst_valid_o); end
    @(negedge clk); ce_i = 1'b0; #1;
    checks++; if (mem_a_o !== 32'h200 || mem_rd_en_o !== 1'b1) begin errors++; $display("FAIL flush_redirect: got %h/%b expected 00000200/1", mem_a_o, mem_rd_en_o); end
    for (int c = 6; c <= 11; c++) begin
      @(negedge clk); #1;
      checks++; if (inst_valid_o !== (c == 10)) begin errors++; $display("FAIL flush_valid c%0d: got %b expected %b", c, inst_valid_o, (c == 10)); end
      if (c == 10) begin
        checks++; if (inst_o !== 32'h00A0_0293 || pc_o !== 32'h200) begin errors++; $display("FAIL flush_inst: got %h@%h expected 00a00293@00000200", inst_o, pc_o); end
      end
    end
  endtask

  task automatic test_valid_stall;
    start_fetch(32'h100);
    repeat (5) @(negedge clk);
    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0513 || pc_o !== 32'h100) begin errors++; $display("FAIL stall_hold k%0d: got v=%b %h@%h expected 1 00100513@00000100", k, inst_valid_o, inst_o, pc_o); end
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL stall_req_hold k%0d: got %b expected 1", k, stall_req_o); end
    end
    @(negedge clk); stall_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b1 || stall_req_o !== 1'b0) begin errors++; $display("FAIL stall_release: got v=%b sr=%b expected 1/0", inst_valid_o, stall_req_o); end
    @(negedge clk); #1;
    checks++; if (inst_valid_o !== 1'b0 || stall_req_o !== 1'b1) begin errors++; $display("FAIL stall_consumed: got v=%b sr=%b expected 0/1", inst_valid_o, stall_req_o); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a;
    start_fetch(32'hFFFF_FFFE);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      exp_a = 32'hFFFF_FFFE + c - 1;
      if (c <= 4) begin
        checks++; if (mem_a_o !== exp_a) begin errors++; $display("FAIL wrap_addr c%0d: got %h expected %h", c, mem_a_o, exp_a); end
      end
      if (c == 6) begin
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_10B7 || pc_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_inst: got v=%b %h@%h expected 1 000010b7@fffffffe", inst_valid_o, inst_o, pc_o); end
      end
    end
  endtask

  task automatic test_async_reset;
    start_fetch(32'h300);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mem_a_o !== 32'h303) begin errors++; $display("FAIL arst_pre_addr: got %h expected 00000303", mem_a_o); end
    #1; rst = 1'b0; #1;
    checks++; if (mem_rd_en_o !== 1'b0 || mem_a_o !== 32'h0 || stall_req_o !== 1'b1) begin errors++; $display("FAIL arst_comb: got rd=%b a=%h sr=%b expected 0/0/1", mem_rd_en_o, mem_a_o, stall_req_o); end
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL arst_regs: got v=%b %h@%h expected 0 0@0", inst_valid_o, inst_o, pc_o); end
    @(negedge clk); rst = 1'b1; pc_i = 32'h300; ce_i = 1'b1;
    @(negedge clk); ce_i = 1'b0; #1;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      if (c <= 4) begin
        checks++; if (mem_a_o !== 32'h300 + c - 1) begin errors++; $display("FAIL arst_restart_addr c%0d: got %h expected %h", c, mem_a_o, 32'h300 + c - 1); end
      end
    end
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_006F || pc_o !== 32'h300) begin errors++; $display("FAIL arst_restart_inst: got v=%b %h@%h expected 1 0000006f@00000300", inst_valid_o, inst_o, pc_o); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; pc_i = '0; ce_i = 1'b0; branch_flag_i = 1'b0;
    stall_i = 1'b0; mem_gnt_i = 1'b1;
    test_reset;
    test_basic;
    test_grant_gap;
    test_flush;
    test_valid_stall;
    test_wrap;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

endmodule
